avmm_export_bridge_mc: RTL
==========================

// Module: avmm_export_bridge_mc
// PURPOSE
//  Parametrised multi-channel Avalon-MM export bridge. Accepts single-beat transfers from the HPS-side
//  export slave and routes each to one of NUM_CH fabric register channels, decoded from the upper
//  address bits. Adds per-access timeout, error readback data and error counting.
//  Sits between the Qsys export conduit and the FPGA peripheral register blocks.
// PARAMETERS
//  ADDR_W    8             upstream word address width; upper CH_W bits select the channel
//  DATA_W    32            data width, multiple of 8
//  NUM_CH    4             downstream channels, 1..16; CH_W = max(1,$clog2(NUM_CH)) (localparam)
//  TIMEOUT   255           max cycles in ISSUE before abort, 1..65535
//  ERR_DATA  32'hDEAD_BEEF readdata returned on a timed-out or decode-error read (DATA_W wide)
// PORTS
//  clk_clk          in   1               sole clock
//  reset_reset_n    in   1               synchronous, active-low reset
//  avs_address      in   ADDR_W          upstream address
//  avs_read         in   1               upstream read request
//  avs_write        in   1               upstream write request
//  avs_writedata    in   DATA_W          upstream write data
//  avs_byteenable   in   DATA_W/8        upstream byte enables
//  avs_readdata     out  DATA_W          upstream read data, valid when avs_waitrequest=0
//  avs_waitrequest  out  1               upstream stall
//  avm_address      out  ADDR_W-CH_W     shared downstream address (channel bits stripped)
//  avm_writedata    out  DATA_W          shared downstream write data
//  avm_byteenable   out  DATA_W/8        shared downstream byte enables
//  avm_read         out  NUM_CH          one-hot per-channel read strobe
//  avm_write        out  NUM_CH          one-hot per-channel write strobe
//  avm_readdata     in   NUM_CH*DATA_W   flattened, channel i at [i*DATA_W +: DATA_W]
//  avm_waitrequest  in   NUM_CH          per-channel stall
//  err_clear        in   1               clears err_sticky and err_count
//  err_sticky       out  1               set on any timeout or decode error
//  err_count        out  16              saturating error count
//  busy             out  1               high when state != IDLE
// BEHAVIOUR
//  Reset (reset_reset_n=0 at posedge): state=IDLE; avs_waitrequest=1; avs_readdata=0; avm_read/write=0;
//   avm_address/writedata/byteenable=0; err_sticky=0; err_count=0; timer=0. Reset aborts any access
//   mid-flight: strobes drop on the next edge, no response is returned.
//  avs_waitrequest=1 in every state except RESP; RESP lasts exactly one cycle.
//  FSM: IDLE -> ISSUE | RESP ; ISSUE -> RESP ; RESP -> IDLE.
//   IDLE : on avs_read|avs_write latch address, data, byteenable, op (write wins if both high),
//          ch = avs_address[ADDR_W-1 -: CH_W]. ch<NUM_CH -> ISSUE; ch>=NUM_CH -> RESP with err.
//   ISSUE: drive avm_read[ch] or avm_write[ch] (registered, held stable). When avm_waitrequest[ch]=0
//          at an edge: capture avm_readdata[ch] (reads), drop strobe, -> RESP. timer counts cycles
//          in ISSUE; when timer==TIMEOUT-1 and waitrequest still high: drop strobe, -> RESP with err.
//          Completion on the same edge as timeout expiry counts as success.
//   RESP : avs_waitrequest=0; avs_readdata = captured data, ERR_DATA on errored read, 0 on write.
//  Errored writes are discarded downstream (decode err) or abandoned (timeout); upstream still
//   completes. Min latency, zero-wait channel: request seen cycle 0, strobe cycle 1, RESP cycle 2.
//  A request still high in the cycle after RESP is a new transfer (Avalon semantics).
//  Errors: err_sticky<=1, err_count<=err_count+1 saturating at 16'hFFFF, on entry to RESP with err.
//   err_clear wins over a simultaneous error (error in that cycle is dropped).
//  avs_readdata retains its last value outside RESP.
// STRUCTURE
//  Package avmm_bridge_pkg: state_t enum {IDLE,ISSUE,RESP}; err_t {ERR_NONE,ERR_DECODE,ERR_TIMEOUT};
//   ERR_COUNT_W=16.
//  Sub-module avmm_timeout_timer (clear, enable, expire at TIMEOUT-1); FSM and mux stay in top.
// TESTING
//  1 NUM_CH=4, read addr 8'h45 (ch1, off 5), ch1 wait=0 rd=32'h1234_5678 -> avm_read=4'b0010
//    one cycle, avs_readdata=32'h1234_5678 with waitrequest low on cycle 2.
//  2 write addr 8'hC2 data 32'hA5A5_A5A5 be 4'b0011, ch3 waitrequest high 3 cycles -> avm_write[3]
//    held 4 cycles, avm_address=6'h02, upstream completes 1 cycle after accept.
//  3 NUM_CH=3, read addr 8'hC0 (ch3) -> no avm strobe, RESP on cycle 1 with 32'hDEAD_BEEF,
//    err_sticky=1, err_count=1.
//  4 TIMEOUT=8, ch0 waitrequest stuck high -> strobe for 8 cycles, ERR_DATA returned, err_count+1;
//    then err_clear and error on same cycle -> err_count=0, err_sticky=0.
//  5 reset_reset_n low during ISSUE -> next edge all strobes 0, waitrequest 1, counters 0;
//    back-to-back reads with request held after RESP -> two separate transfers.

Source files
------------

// File: rtl/avmm_bridge_pkg.sv
// Shared types and constants for the multi-channel Avalon-MM export bridge.
package avmm_bridge_pkg;

  localparam int unsigned ERR_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

endpackage

// File: rtl/avmm_timeout_timer.sv
// Per-access cycle counter; expire_o is high during the TIMEOUT-th cycle of an access.
module avmm_timeout_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt_q;
  logic             expire_q;

  // Count cycles while enabled; expire flag is precomputed so it lines up with the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q    <= '0;
      expire_q <= (TIMEOUT == 1);
    end else if (enable_i) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      expire_q <= ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT - 1));
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/avmm_export_bridge_mc.sv
// HPS export slave to NUM_CH fabric register channels, with timeout and error accounting.
module avmm_export_bridge_mc
  import avmm_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [ADDR_W-1:0]            avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [DATA_W-1:0]            avs_writedata,
  input  logic [DATA_W/8-1:0]          avs_byteenable,
  output logic [DATA_W-1:0]            avs_readdata,
  output logic                         avs_waitrequest,
  output logic [ADDR_W-((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] avm_address,
  output logic [DATA_W-1:0]            avm_writedata,
  output logic [DATA_W/8-1:0]          avm_byteenable,
  output logic [NUM_CH-1:0]            avm_read,
  output logic [NUM_CH-1:0]            avm_write,
  input  logic [NUM_CH*DATA_W-1:0]     avm_readdata,
  input  logic [NUM_CH-1:0]            avm_waitrequest,
  input  logic                         err_clear,
  output logic                         err_sticky,
  output logic [ERR_COUNT_W-1:0]       err_count,
  output logic                         busy
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AO_W = ADDR_W - CH_W;
  localparam int unsigned BE_W = DATA_W / 8;

  state_t                 state_q;
  logic                   op_wr_q;
  logic [CH_W-1:0]        ch_q;
  logic [DATA_W-1:0]      avs_readdata_q;
  logic                   avs_waitrequest_q;
  logic [AO_W-1:0]        avm_address_q;
  logic [DATA_W-1:0]      avm_writedata_q;
  logic [BE_W-1:0]        avm_byteenable_q;
  logic [NUM_CH-1:0]      avm_read_q;
  logic [NUM_CH-1:0]      avm_write_q;
  logic                   err_sticky_q;
  logic [ERR_COUNT_W-1:0] err_count_q;
  logic                   busy_q;

  logic [CH_W-1:0]        req_ch_c;
  logic                   req_c;
  logic                   req_ok_c;
  logic [NUM_CH-1:0]      req_onehot_c;
  logic                   sel_wait_c;
  logic [DATA_W-1:0]      sel_rdata_c;
  logic                   tmr_expire;
  err_t                   err_kind_c;

  assign req_ch_c     = avs_address[ADDR_W-1 -: CH_W];
  assign req_c        = avs_read | avs_write;
  assign req_ok_c     = (32'(req_ch_c) < NUM_CH);
  assign req_onehot_c = NUM_CH'(1) << req_ch_c;

  // Select the addressed channel's handshake and read data.
  always_comb begin
    sel_wait_c  = 1'b1;
    sel_rdata_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_wait_c  = avm_waitrequest[i];
        sel_rdata_c = avm_readdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Classify an error occurring on this edge; a completing channel beats expiry.
  always_comb begin
    err_kind_c = ERR_NONE;
    if (state_q == IDLE && req_c && !req_ok_c) begin
      err_kind_c = ERR_DECODE;
    end else if (state_q == ISSUE && sel_wait_c && tmr_expire) begin
      err_kind_c = ERR_TIMEOUT;
    end
  end

  avmm_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .clear_i  (state_q != ISSUE),
    .enable_i (state_q == ISSUE),
    .expire_o (tmr_expire)
  );

  // Transfer FSM with registered upstream response and downstream strobes.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q           <= IDLE;
      op_wr_q           <= 1'b0;
      ch_q              <= '0;
      avs_readdata_q    <= '0;
      avs_waitrequest_q <= 1'b1;
      avm_address_q     <= '0;
      avm_writedata_q   <= '0;
      avm_byteenable_q  <= '0;
      avm_read_q        <= '0;
      avm_write_q       <= '0;
      busy_q            <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_c) begin
            op_wr_q          <= avs_write;
            ch_q             <= req_ch_c;
            avm_address_q    <= avs_address[AO_W-1:0];
            avm_writedata_q  <= avs_writedata;
            avm_byteenable_q <= avs_byteenable;
            busy_q           <= 1'b1;
            if (req_ok_c) begin
              state_q <= ISSUE;
              if (avs_write) avm_write_q <= req_onehot_c;
              else           avm_read_q  <= req_onehot_c;
            end else begin
              state_q           <= RESP;
              avs_waitrequest_q <= 1'b0;
              avs_readdata_q    <= avs_write ? '0 : ERR_DATA;
            end
          end
        end
        ISSUE: begin
          if (!sel_wait_c || err_kind_c == ERR_TIMEOUT) begin
            state_q           <= RESP;
            avm_read_q        <= '0;
            avm_write_q       <= '0;
            avs_waitrequest_q <= 1'b0;
            if (op_wr_q)          avs_readdata_q <= '0;
            else if (!sel_wait_c) avs_readdata_q <= sel_rdata_c;
            else                  avs_readdata_q <= ERR_DATA;
          end
        end
        RESP: begin
          state_q           <= IDLE;
          avs_waitrequest_q <= 1'b1;
          busy_q            <= 1'b0;
        end
        default: begin
          state_q           <= IDLE;
          avs_waitrequest_q <= 1'b1;
          avm_read_q        <= '0;
          avm_write_q       <= '0;
          busy_q            <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag and saturating counter; a clear drops an error on the same edge.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else if (err_clear) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else if (err_kind_c != ERR_NONE) begin
      err_sticky_q <= 1'b1;
      if (err_count_q != '1) err_count_q <= err_count_q + ERR_COUNT_W'(1);
    end
  end

  assign avs_readdata    = avs_readdata_q;
  assign avs_waitrequest = avs_waitrequest_q;
  assign avm_address     = avm_address_q;
  assign avm_writedata   = avm_writedata_q;
  assign avm_byteenable  = avm_byteenable_q;
  assign avm_read        = avm_read_q;
  assign avm_write       = avm_write_q;
  assign err_sticky      = err_sticky_q;
  assign err_count       = err_count_q;
  assign busy            = busy_q;

endmodule
